out_monitor: RTL and testbench

Downstream watchdog for the two-output control FSM: consumes its registered `out1`/`out2` and watches for activity on either line. It counts toggles, raises a warning after a half-timeout of silence, and latches an alarm after a full timeout. This is how FSM deadlock (outputs frozen) is caught at run time. The block sits directly after the FSM and feeds the status/interrupt logic.

---
 rtl/out_monitor_pkg.sv | 22 ++
 rtl/act_detect.sv | 31 +++
 rtl/out_monitor.sv | 128 ++++++++++++
 tb/tb_out_monitor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module  : out_monitor_pkg
// Brief   : State type and shared state-encoding constants for out_monitor.
// Revision: 1.0 - initial release
// ============================================================================
package out_monitor_pkg;

    localparam logic [1:0] c_state_idle  = 2'd0;
    localparam logic [1:0] c_state_watch = 2'd1;
    localparam logic [1:0] c_state_warn  = 2'd2;
    localparam logic [1:0] c_state_alarm = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = c_state_idle,
        WATCH = c_state_watch,
        WARN  = c_state_warn,
        ALARM = c_state_alarm
    } state_t;

endpackage : out_monitor_pkg
`default_nettype wire

// File: rtl/act_detect.sv
`default_nettype none
// ============================================================================
// Module  : act_detect
// Brief   : Samples the upstream outputs and flags a change on either line.
// Revision: 1.0 - initial release
// ============================================================================
module act_detect (
    input  logic clk,
    input  logic rst,
    input  logic out1,
    input  logic out2,
    output logic act
);

    logic r_p1;
    logic r_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1 <= 1'b0;
            r_p2 <= 1'b0;
        end else begin
            r_p1 <= out1;
            r_p2 <= out2;
        end
    end

    assign act = (out1 ^ r_p1) | (out2 ^ r_p2);

endmodule : act_detect
`default_nettype wire

// File: rtl/out_monitor.sv
`default_nettype none
// ============================================================================
// Module  : out_monitor
// Brief   : Activity watchdog on the control FSM outputs: counts activity,
//           warns after TIMEOUT/2 quiet cycles, latches alarm after TIMEOUT.
//           Define OUT_MONITOR_SAT_EN to make act_cnt saturate instead of wrap.
// Revision: 1.0 - initial release
// ============================================================================
module out_monitor
    import out_monitor_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             out1_i,
    input  logic             out2_i,
    output logic [CNT_W-1:0] act_cnt,
    output logic             stall_o,
    output logic             alarm_o,
    output logic [1:0]       state_o
);

    localparam int QW = $clog2(TIMEOUT + 1);
    localparam logic [QW-1:0] c_half    = QW'(TIMEOUT / 2);
    localparam logic [QW-1:0] c_half_m1 = QW'(TIMEOUT / 2 - 1);
    localparam logic [QW-1:0] c_full    = QW'(TIMEOUT);
    localparam logic [QW-1:0] c_full_m1 = QW'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_nx;
    logic [QW-1:0]    r_q;
    logic [QW-1:0]    w_q_nx;
    logic [CNT_W-1:0] r_act_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_act;

    act_detect u_act_detect (
        .clk  (clk),
        .rst  (rst),
        .out1 (out1_i),
        .out2 (out2_i),
        .act  (w_act)
    );

`ifdef OUT_MONITOR_SAT_EN
    assign w_cnt_inc = (&r_act_cnt) ? r_act_cnt : r_act_cnt + CNT_W'(1);
`else
    assign w_cnt_inc = r_act_cnt + CNT_W'(1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_q       <= '0;
            r_act_cnt <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_q       <= w_q_nx;
            r_act_cnt <= w_cnt_nx;
        end
    end

    // An unknown act falls to the else branches, so it never counts as activity.
    always_comb begin
        w_state_nx = r_state;
        w_q_nx     = r_q;
        w_cnt_nx   = r_act_cnt;
        if (!en) begin
            w_state_nx = IDLE;
            w_q_nx     = '0;
        end else if (clr) begin
            w_state_nx = WATCH;
            w_q_nx     = '0;
            w_cnt_nx   = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_nx = WATCH;
                    w_q_nx     = '0;
                end
                WATCH: begin
                    if (w_act) begin
                        w_q_nx   = '0;
                        w_cnt_nx = w_cnt_inc;
                    end else if (r_q == c_half_m1) begin
                        w_q_nx     = c_half;
                        w_state_nx = WARN;
                    end else begin
                        w_q_nx = r_q + QW'(1);
                    end
                end
                WARN: begin
                    if (w_act) begin
                        w_q_nx     = '0;
                        w_cnt_nx   = w_cnt_inc;
                        w_state_nx = WATCH;
                    end else if (r_q == c_full_m1) begin
                        w_q_nx     = c_full;
                        w_state_nx = ALARM;
                    end else begin
                        w_q_nx = r_q + QW'(1);
                    end
                end
                ALARM: begin
                    w_state_nx = ALARM;
                end
                default: begin
                    w_state_nx = IDLE;
                    w_q_nx     = '0;
                end
            endcase
        end
    end

    always_comb begin
        state_o = r_state;
        stall_o = (r_state == WARN);
        alarm_o = (r_state == ALARM);
        act_cnt = r_act_cnt;
    end

endmodule : out_monitor
`default_nettype wire

// File: tb/tb_out_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_out_monitor
// Brief   : Self-checking bench for out_monitor with a quiet-run based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_out_monitor;

    localparam int TIMEOUT = 16;
    localparam int HALF    = TIMEOUT / 2;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;
    logic       out1_i;
    logic       out2_i;
    logic [7:0] act_cnt;
    logic       stall_o;
    logic       alarm_o;
    logic [1:0] state_o;
    logic [3:0] s_act_cnt;
    logic       s_stall;
    logic       s_alarm;
    logic [1:0] s_state;

    int  tests;
    int  fails;
    bit  cmp_on;

    out_monitor #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .out1_i(out1_i), .out2_i(out2_i),
        .act_cnt(act_cnt), .stall_o(stall_o), .alarm_o(alarm_o), .state_o(state_o)
    );

    out_monitor #(.TIMEOUT(TIMEOUT), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .out1_i(out1_i), .out2_i(out2_i),
        .act_cnt(s_act_cnt), .stall_o(s_stall), .alarm_o(s_alarm), .state_o(s_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: "active" after the first enabled edge, length of the current quiet
    // run, sticky alarm, and raw number of counted activity cycles since clear.
    typedef struct packed {
        bit active;
        bit alarm;
        int quiet;
        int raw;
        bit p1;
        bit p2;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t step(mdl_t cur, bit e, bit c, bit a, bit b);
        mdl_t n   = cur;
        bit   act = (a != cur.p1) || (b != cur.p2);
        n.p1 = a;
        n.p2 = b;
        if (!e) begin
            n.active = 1'b0;
            n.quiet  = 0;
            n.alarm  = 1'b0;
        end else if (c) begin
            n.active = 1'b1;
            n.quiet  = 0;
            n.raw    = 0;
            n.alarm  = 1'b0;
        end else if (!cur.active) begin
            n.active = 1'b1;
            n.quiet  = 0;
        end else if (!cur.alarm) begin
            if (act) begin
                n.raw   = cur.raw + 1;
                n.quiet = 0;
            end else begin
                n.quiet = cur.quiet + 1;
                if (n.quiet >= TIMEOUT) n.alarm = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic int exp_state(mdl_t x);
        if (!x.active)        return 0;
        if (x.alarm)          return 3;
        if (x.quiet >= HALF)  return 2;
        return 1;
    endfunction

    function automatic int exp_cnt(int raw, int w);
        int mx = (1 << w) - 1;
`ifdef OUT_MONITOR_SAT_EN
        return (raw > mx) ? mx : raw;
`else
        return raw & mx;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else     m <= step(m, en, clr, out1_i, out2_i);
    end

    task automatic chk(string name, int got, int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("state", int'(state_o), exp_state(m));
            chk("stall", int'(stall_o), int'(exp_state(m) == 2));
            chk("alarm", int'(alarm_o), int'(exp_state(m) == 3));
            chk("cnt8", int'(act_cnt), exp_cnt(m.raw, 8));
            chk("cnt4", int'(s_act_cnt), exp_cnt(m.raw, 4));
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_state"}, int'(state_o), 0);
        chk({tag, "_stall"}, int'(stall_o), 0);
        chk({tag, "_alarm"}, int'(alarm_o), 0);
        chk({tag, "_cnt"}, int'(act_cnt), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        int den;
        tests = 0; fails = 0; cmp_on = 1'b0;
        rst = 1'b0; en = 1'b0; clr = 1'b0; out1_i = 1'b0; out2_i = 1'b0;
        #2 rst = 1'b1;
        tick(2);
        cmp_on = 1'b1;
        chk_zero("reset");
        rst = 1'b0;
        tick();
        chk("idle_hold", int'(state_o), 0);

        // Quiet from enable: warn after 8 edges, alarm after 16.
        en = 1'b1;
        tick();
        chk("e0_watch", int'(state_o), 1);
        tick(7);
        chk("e7_stall", int'(stall_o), 0);
        tick();
        chk("e8_stall", int'(stall_o), 1);
        tick(7);
        chk("e15_alarm", int'(alarm_o), 0);
        tick();
        chk("e16_alarm", int'(alarm_o), 1);
        chk("e16_cnt", int'(act_cnt), 0);

        // Clear leaves ALARM.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_alarm", int'(alarm_o), 0);
        chk("clr_state", int'(state_o), 1);

        // Periodic toggling keeps the monitor in WATCH.
        for (int i = 0; i < 100; i++) begin
            if (i % 5 == 0) out1_i = ~out1_i;
            tick();
            if (stall_o || alarm_o) chk("toggle_quiet", int'({stall_o, alarm_o}), 0);
        end
        chk("toggle_cnt", int'(act_cnt), 20);
`ifdef OUT_MONITOR_SAT_EN
        chk("cnt4_20", int'(s_act_cnt), 15);
`else
        chk("cnt4_20", int'(s_act_cnt), 4);
`endif

        // Four more quiet edges reach WARN; activity returns to WATCH.
        tick(4);
        chk("warn_state", int'(state_o), 2);
        out2_i = ~out2_i;
        tick();
        chk("rewatch_state", int'(state_o), 1);
        chk("rewatch_stall", int'(stall_o), 0);
        chk("rewatch_cnt", int'(act_cnt), 21);
        tick(15);
        chk("q_restart_alarm", int'(alarm_o), 0);
        tick();
        chk("q_restart_alarm2", int'(alarm_o), 1);

        // Activity in ALARM is ignored.
        for (int i = 0; i < 3; i++) begin
            out1_i = ~out1_i;
            tick();
        end
        chk("alarm_hold", int'(alarm_o), 1);
        chk("alarm_cnt_frozen", int'(act_cnt), 21);

        // Clear beats simultaneous activity.
        clr = 1'b1; out1_i = ~out1_i;
        tick();
        clr = 1'b0;
        chk("clr_act_cnt", int'(act_cnt), 0);
        chk("clr_act_state", int'(state_o), 1);

        // Disable holds the count.
        out2_i = ~out2_i;
        tick();
        en = 1'b0;
        tick();
        chk("dis_state", int'(state_o), 0);
        chk("dis_cnt", int'(act_cnt), 1);
        en = 1'b1;
        tick(9);
        chk("warn2_state", int'(state_o), 2);

        // Asynchronous reset between edges.
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        tick();
        rst = 1'b0;

        // Randomized phase.
        for (int seg = 0; seg < 16; seg++) begin
            case (seg % 4)
                0:       den = 2;
                1:       den = 6;
                2:       den = 40;
                default: den = 1000;
            endcase
            for (int i = 0; i < 200; i++) begin
                rst = 1'b0;
                if ($urandom_range(0, 399) == 0) begin
                    rst = 1'b1;
                    #1;
                    chk_zero("rnd_rst");
                end
                en  = ($urandom_range(0, 49) != 0);
                clr = ($urandom_range(0, 63) == 0);
                if ($urandom_range(0, den - 1) == 0) out1_i = ~out1_i;
                if ($urandom_range(0, den - 1) == 0) out2_i = ~out2_i;
                tick();
            end
        end
        rst = 1'b0;
        tick(2);
        cmp_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_out_monitor
`default_nettype wire
